// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encodings,
// the NOP instruction word, the sequential PC step and the timeout counter width.
package instr_fetch_unit_pkg;

    typedef enum logic [0:0] {
        IF_ST_IDLE = 1'b0,
        IF_ST_REQ  = 1'b1
    } if_state_e;

    // addi x0, x0, 0
    localparam logic [31:0] IF_NOP     = 32'h0000_0013;
    localparam logic [31:0] IF_PC_STEP = 32'd4;
    localparam int unsigned IF_TMO_W   = 8;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus. The fetch unit is the master;
// the memory answers with ack and the instruction word in the same cycle.
interface instr_fetch_unit_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/instr_fetch_unit_fetch_timeout_ctr.sv
// Cycle counter for an outstanding instruction-memory request. Cleared while
// no request is outstanding, counts every request cycle, and flags the cycle
// on which the LIMIT-th request cycle is being spent.
module fetch_timeout_ctr
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);
    logic [IF_TMO_W-1:0] cnt_q;
    logic [IF_TMO_W-1:0] cnt_d;

    // Next count: clear has priority over enable, otherwise hold
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {IF_TMO_W{1'b0}};
        end else if (en) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= {IF_TMO_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Count is zero on the first request cycle, so LIMIT-1 marks the last allowed one
    assign tc = (cnt_q == IF_TMO_W'(LIMIT - 1));

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, performs one imem fetch per fetch_go
// pulse and presents the result to the IF/ID latch.
// Optional feature macro: IFETCH_MISALIGN_CHECK_EN (reject fetches from a
// PC whose low two bits are non-zero).
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       DATA_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_PC    = {ADDR_W{1'b0}},
    parameter int unsigned       TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wb_if_wren,
    input  logic                branch_taken,
    input  logic [ADDR_W-1:0]   branch_target,
    input  logic                fetch_go,
    instr_fetch_unit_if.master  imem,
    output logic [ADDR_W-1:0]   pc_out,
    output logic [DATA_W-1:0]   instr_out,
    output logic                instr_valid,
    output logic                fetch_busy,
    output logic                fetch_err,
    output logic                fetch_misalign
);
    if_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
    logic              pend_vld_q, pend_vld_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] pc_out_q, pc_out_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;

    logic              tmo_tc_s;
    logic              misalign_s;
    logic              go_accept_s;
    logic              start_s;
    logic              ack_s;
    logic              tmo_s;
    logic              done_s;
    logic [ADDR_W-1:0] base_pc_s;
    logic [ADDR_W-1:0] upd_pc_s;

`ifdef IFETCH_MISALIGN_CHECK_EN
    logic              mis_q, mis_d;
    assign misalign_s = (pc_q[1:0] != 2'b00);
`else
    assign misalign_s = 1'b0;
`endif

    assign go_accept_s = fetch_go && (state_q == IF_ST_IDLE);
    assign start_s     = go_accept_s && !misalign_s;
    assign ack_s       = (state_q == IF_ST_REQ) && imem.ack;
    // An ack on the terminal cycle wins over the timeout
    assign tmo_s       = (state_q == IF_ST_REQ) && !imem.ack && tmo_tc_s;
    assign done_s      = ack_s || tmo_s;

    // Updates during a fetch chain from the not-yet-applied pending PC
    assign base_pc_s = pend_vld_q ? pend_pc_q : pc_q;
    assign upd_pc_s  = branch_taken ? branch_target : (base_pc_s + ADDR_W'(IF_PC_STEP));

    fetch_timeout_ctr #(
        .LIMIT (TIMEOUT_CYC)
    ) u_tmo_ctr (
        .clk   (clk),
        .reset (reset),
        .clr   (state_q != IF_ST_REQ),
        .en    (state_q == IF_ST_REQ),
        .tc    (tmo_tc_s)
    );

    // FSM next state: a fetch is outstanding from accepted go until ack or timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            IF_ST_IDLE: begin
                if (start_s) state_d = IF_ST_REQ;
                else         state_d = IF_ST_IDLE;
            end
            IF_ST_REQ: begin
                if (done_s) state_d = IF_ST_IDLE;
                else        state_d = IF_ST_REQ;
            end
            default: state_d = IF_ST_IDLE;
        endcase
    end

    // PC update: immediate when idle, deferred through the pending register during a fetch
    always_comb begin
        pc_d       = pc_q;
        pend_pc_d  = pend_pc_q;
        pend_vld_d = pend_vld_q;
        if (state_q == IF_ST_IDLE) begin
            if (wb_if_wren) pc_d = upd_pc_s;
            else            pc_d = pc_q;
            pend_vld_d = 1'b0;
        end else if (done_s) begin
            if (wb_if_wren)      pc_d = upd_pc_s;
            else if (pend_vld_q) pc_d = pend_pc_q;
            else                 pc_d = pc_q;
            pend_vld_d = 1'b0;
        end else begin
            if (wb_if_wren) begin
                pend_pc_d  = upd_pc_s;
                pend_vld_d = 1'b1;
            end else begin
                pend_pc_d  = pend_pc_q;
                pend_vld_d = pend_vld_q;
            end
        end
    end

    // Registered outputs: request launch, completion, timeout and misalign reporting
    always_comb begin
        req_d    = req_q;
        addr_d   = addr_q;
        pc_out_d = pc_out_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        err_d    = err_q;
`ifdef IFETCH_MISALIGN_CHECK_EN
        mis_d    = mis_q;
`endif
        if (go_accept_s && misalign_s) begin
            pc_out_d = pc_q;
            instr_d  = DATA_W'(IF_NOP);
            valid_d  = 1'b1;
            err_d    = 1'b1;
`ifdef IFETCH_MISALIGN_CHECK_EN
            mis_d    = 1'b1;
`endif
        end else if (start_s) begin
            req_d   = 1'b1;
            addr_d  = pc_q;
            valid_d = 1'b0;
            busy_d  = 1'b1;
        end else if (ack_s) begin
            req_d    = 1'b0;
            pc_out_d = addr_q;
            instr_d  = imem.rdata;
            valid_d  = 1'b1;
            busy_d   = 1'b0;
        end else if (tmo_s) begin
            req_d    = 1'b0;
            pc_out_d = addr_q;
            instr_d  = DATA_W'(IF_NOP);
            valid_d  = 1'b1;
            busy_d   = 1'b0;
            err_d    = 1'b1;
        end else begin
            req_d = req_q;
        end
    end

    // State register with synchronous reset; a reset mid-fetch abandons the request
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IF_ST_IDLE;
            pc_q       <= RESET_PC;
            pend_pc_q  <= {ADDR_W{1'b0}};
            pend_vld_q <= 1'b0;
            req_q      <= 1'b0;
            addr_q     <= {ADDR_W{1'b0}};
            pc_out_q   <= {ADDR_W{1'b0}};
            instr_q    <= DATA_W'(IF_NOP);
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef IFETCH_MISALIGN_CHECK_EN
            mis_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_pc_q  <= pend_pc_d;
            pend_vld_q <= pend_vld_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            pc_out_q   <= pc_out_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
`ifdef IFETCH_MISALIGN_CHECK_EN
            mis_q      <= mis_d;
`endif
        end
    end

    assign imem.req    = req_q;
    assign imem.addr   = addr_q;
    assign pc_out      = pc_out_q;
    assign instr_out   = instr_q;
    assign instr_valid = valid_q;
    assign fetch_busy  = busy_q;
    assign fetch_err   = err_q;
`ifdef IFETCH_MISALIGN_CHECK_EN
    assign fetch_misalign = mis_q;
`else
    assign fetch_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: reset state, a table of fetches,
// hand-written corner sequences (pending PC, timeout, reset mid-fetch,
// misalign) and randomized fetches checked against a PC-sequence model.
module tb_instr_fetch_unit;
    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned TMO = 255;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          reset;
    logic          wb_if_wren;
    logic          branch_taken;
    logic [AW-1:0] branch_target;
    logic          fetch_go;
    logic [AW-1:0] pc_out;
    logic [DW-1:0] instr_out;
    logic          instr_valid;
    logic          fetch_busy;
    logic          fetch_err;
    logic          fetch_misalign;

    instr_fetch_unit_if #(.ADDR_W(AW), .DATA_W(DW)) imem_bus ();

    instr_fetch_unit #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .RESET_PC    (32'h0000_0000),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .wb_if_wren     (wb_if_wren),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .fetch_go       (fetch_go),
        .imem           (imem_bus),
        .pc_out         (pc_out),
        .instr_out      (instr_out),
        .instr_valid    (instr_valid),
        .fetch_busy     (fetch_busy),
        .fetch_err      (fetch_err),
        .fetch_misalign (fetch_misalign)
    );

    always #5 clk = ~clk;

    int          n_tot  = 0;
    int          n_pass = 0;
    logic [31:0] m_pc;   // architectural PC as the sequence of committed updates

    typedef struct {
        logic        do_wren;
        logic        taken;
        logic [31:0] target;
        logic [31:0] rdata;
        int          dly;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wren(input logic en, input logic t, input logic [31:0] tgt);
        wb_if_wren    = en;
        branch_taken  = t;
        branch_target = tgt;
        if (en) m_pc = t ? tgt : (m_pc + 32'd4);
    endtask

    task automatic rand_wren(input logic en);
        logic [31:0] tgt;
        tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
        if (en) set_wren(1'b1, 1'($urandom_range(0, 1)), tgt);
        else    set_wren(1'b0, 1'b0, 32'h0);
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        set_wren(1'b0, 1'b0, 32'h0);
        fetch_go = 1'b0;
        imem_bus.ack = 1'b0;
        step();
        step();
        reset = 1'b0;
        m_pc = 32'h0;
    endtask

    // One complete fetch: go (optionally with a PC commit), dly wait cycles, then ack.
    // wmask bit k commits a random PC update during request cycle k+1.
    task automatic fetch_txn(input string nm, input logic [31:0] rd, input int dly,
                             input logic [31:0] exp_addr, input logic go_w, input logic [7:0] wmask);
        fetch_go = 1'b1;
        rand_wren(go_w);
        step();
        fetch_go = 1'b0;
        chk({nm, "_req"},   64'(imem_bus.req),  64'd1);
        chk({nm, "_addr"},  64'(imem_bus.addr), 64'(exp_addr));
        chk({nm, "_busy"},  64'(fetch_busy),    64'd1);
        chk({nm, "_vlow"},  64'(instr_valid),   64'd0);
        for (int k = 0; k <= dly; k++) begin
            if (k > 0) chk({nm, "_req_hold"}, {31'd0, imem_bus.req, imem_bus.addr}, {32'd1, exp_addr});
            rand_wren(wmask[k]);
            if (k == dly) begin
                imem_bus.ack   = 1'b1;
                imem_bus.rdata = rd;
            end
            step();
        end
        imem_bus.ack = 1'b0;
        set_wren(1'b0, 1'b0, 32'h0);
        chk({nm, "_valid"}, 64'(instr_valid),   64'd1);
        chk({nm, "_pcout"}, 64'(pc_out),        64'(exp_addr));
        chk({nm, "_instr"}, 64'(instr_out),     64'(rd));
        chk({nm, "_reqlo"}, 64'(imem_bus.req),  64'd0);
        chk({nm, "_idle"},  64'(fetch_busy),    64'd0);
    endtask

    initial begin
        logic [31:0] ea;
        int          n;

        vecs[0] = '{1'b0, 1'b0, 32'h0,         32'h0050_0093, 0, 32'h0000_0000};
        vecs[1] = '{1'b1, 1'b0, 32'h0,         32'h1111_1111, 1, 32'h0000_0004};
        vecs[2] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 32'h2222_2222, 2, 32'hFFFF_FFFC};
        vecs[3] = '{1'b1, 1'b0, 32'h0,         32'h3333_3333, 0, 32'h0000_0000};
        vecs[4] = '{1'b1, 1'b1, 32'h0000_0100, 32'h4444_4444, 3, 32'h0000_0100};

        imem_bus.ack   = 1'b0;
        imem_bus.rdata = 32'h0;
        reset_dut();

        // Reset state
        chk("rst_req",   64'(imem_bus.req),   64'd0);
        chk("rst_addr",  64'(imem_bus.addr),  64'd0);
        chk("rst_pcout", 64'(pc_out),         64'd0);
        chk("rst_instr", 64'(instr_out),      64'(NOP));
        chk("rst_valid", 64'(instr_valid),    64'd0);
        chk("rst_busy",  64'(fetch_busy),     64'd0);
        chk("rst_err",   64'(fetch_err),      64'd0);
        chk("rst_mis",   64'(fetch_misalign), 64'd0);

        // Table: optional idle PC commit, then a fetch with a given ack delay
        for (int i = 0; i < 5; i++) begin
            if (vecs[i].do_wren) begin
                set_wren(1'b1, vecs[i].taken, vecs[i].target);
                step();
                set_wren(1'b0, 1'b0, 32'h0);
            end
            fetch_txn($sformatf("vec%0d", i), vecs[i].rdata, vecs[i].dly, vecs[i].exp_addr, 1'b0, 8'h00);
        end

        // Commit in the same cycle as fetch_go: fetch uses the old PC, next fetch the new one
        fetch_txn("samecyc", 32'hAAAA_0001, 1, 32'h0000_0100, 1'b1, 8'h00);
        fetch_txn("samecyc_nxt", 32'hAAAA_0002, 0, m_pc, 1'b0, 8'h00);

        // Branch committed while a fetch is outstanding takes effect after the fetch
        reset_dut();
        fetch_go = 1'b1;
        step();
        fetch_go = 1'b0;
        set_wren(1'b1, 1'b1, 32'h0000_0040);
        step();
        set_wren(1'b0, 1'b0, 32'h0);
        step();
        imem_bus.ack   = 1'b1;
        imem_bus.rdata = 32'h0BAD_0001;
        step();
        imem_bus.ack = 1'b0;
        chk("pend_pcout", 64'(pc_out),    64'd0);
        chk("pend_instr", 64'(instr_out), 64'h0BAD_0001);
        fetch_txn("pend_nxt", 32'h0BAD_0002, 0, 32'h0000_0040, 1'b0, 8'h00);

        // Ack on the last allowed request cycle completes normally
        ea = m_pc;
        fetch_go = 1'b1;
        step();
        fetch_go = 1'b0;
        for (int k = 1; k < TMO; k++) step();
        chk("ack255_req", 64'(imem_bus.req), 64'd1);
        imem_bus.ack   = 1'b1;
        imem_bus.rdata = 32'h0C0F_FEE0;
        step();
        imem_bus.ack = 1'b0;
        chk("ack255_err",   64'(fetch_err),   64'd0);
        chk("ack255_valid", 64'(instr_valid), 64'd1);
        chk("ack255_instr", 64'(instr_out),   64'h0C0F_FEE0);

        // No ack at all: timeout delivers NOP and a sticky error
        fetch_go = 1'b1;
        step();
        fetch_go = 1'b0;
        for (int k = 1; k < TMO; k++) step();
        chk("tmo_req_before", 64'(imem_bus.req), 64'd1);
        step();
        chk("tmo_req",   64'(imem_bus.req), 64'd0);
        chk("tmo_instr", 64'(instr_out),    64'(NOP));
        chk("tmo_valid", 64'(instr_valid),  64'd1);
        chk("tmo_err",   64'(fetch_err),    64'd1);
        chk("tmo_pcout", 64'(pc_out),       64'(ea));
        chk("tmo_busy",  64'(fetch_busy),   64'd0);
        fetch_txn("post_tmo", 32'h5555_0001, 0, m_pc, 1'b0, 8'h00);
        chk("tmo_sticky", 64'(fetch_err), 64'd1);

        // Reset in the middle of a fetch; a late ack is ignored
        fetch_go = 1'b1;
        step();
        fetch_go = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        m_pc = 32'h0;
        imem_bus.ack   = 1'b1;
        imem_bus.rdata = 32'hDEAD_BEEF;
        chk("rstmid_req",   64'(imem_bus.req), 64'd0);
        chk("rstmid_valid", 64'(instr_valid),  64'd0);
        chk("rstmid_instr", 64'(instr_out),    64'(NOP));
        chk("rstmid_err",   64'(fetch_err),    64'd0);
        step();
        imem_bus.ack = 1'b0;
        chk("late_ack", {30'd0, imem_bus.req, instr_valid, fetch_busy, instr_out}, {30'd0, 1'b0, 1'b0, 1'b0, NOP});

        // Misaligned PC
        set_wren(1'b1, 1'b1, 32'h0000_0102);
        step();
        set_wren(1'b0, 1'b0, 32'h0);
`ifdef IFETCH_MISALIGN_CHECK_EN
        fetch_go = 1'b1;
        step();
        fetch_go = 1'b0;
        chk("mis_req",   64'(imem_bus.req),   64'd0);
        chk("mis_flag",  64'(fetch_misalign), 64'd1);
        chk("mis_err",   64'(fetch_err),      64'd1);
        chk("mis_valid", 64'(instr_valid),    64'd1);
        chk("mis_instr", 64'(instr_out),      64'(NOP));
        chk("mis_busy",  64'(fetch_busy),     64'd0);
`else
        fetch_txn("unaligned", 32'h0777_0001, 1, 32'h0000_0102, 1'b0, 8'h00);
        chk("mis_tied", 64'(fetch_misalign), 64'd0);
`endif

        // Randomized fetches against the PC-sequence model
        reset_dut();
        for (int t = 0; t < 40; t++) begin
            n = $urandom_range(0, 2);
            for (int j = 0; j < n; j++) begin
                rand_wren(1'b1);
                step();
            end
            set_wren(1'b0, 1'b0, 32'h0);
            fetch_txn("rand", $urandom, $urandom_range(0, 4), m_pc,
                      1'($urandom_range(0, 3) == 0), 8'($urandom));
        end
        chk("rand_err", 64'(fetch_err), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
